// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, bubble encoding, reset PC and
// the fetch-stage state/entry types.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IDLE: nothing outstanding, WAIT: live request, KILL: stale request to drop.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILL
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: one outstanding request,
// in-order responses at least one cycle after the grant.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage_buf.sv
// Single-entry {inst, pc} holding register that catches a response arriving
// while decode is stalled.
module fetch_buf
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t d,
  output logic         valid,
  output fetch_entry_t q
);

  // NOTE: the payload is reset together with valid so a stale entry can never
  // carry X into IF/ID, even though valid alone already qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID register: owns the PC, tracks the
// single outstanding imem request and drops responses made stale by a redirect.
module fetch_stage
  import riscv_pkg::XLEN, riscv_pkg::fetch_state_e, riscv_pkg::IDLE, riscv_pkg::WAIT,
         riscv_pkg::KILL, riscv_pkg::fetch_entry_t, riscv_pkg::align_pc;
#(
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_stage_if.master   imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, tag_pc_q;
  logic            grant, accept;
  logic            buf_load, buf_clear, buf_valid;
  fetch_entry_t    rsp_entry, buf_entry;

  // A response and the next request may share a cycle, giving 1 inst/clk
  // behind a single-cycle memory.
  assign imem.req  = rst_n && !redirect_valid && !stall_d && !buf_valid &&
                     (state_q == IDLE || imem.rvalid);
  assign imem.addr = pc_q;
  assign grant     = imem.req && imem.gnt;
  assign accept    = imem.rvalid && (state_q == WAIT);

  assign rsp_entry = '{inst: imem.rdata, pc: tag_pc_q};
  assign buf_load  = stall_d && accept && !redirect_valid && !flush_d;
  assign buf_clear = redirect_valid || flush_d || !stall_d;

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (rsp_entry),
    .valid (buf_valid),
    .q     (buf_entry)
  );

  // NOTE: state_d gets its default first so no path through this block
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (state_q != IDLE && !imem.rvalid) ? KILL : IDLE;
    end else if (grant) begin
      state_d = WAIT;
    end else if (imem.rvalid && state_q != IDLE) begin
      state_d = IDLE;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= align_pc(RESET_PC);
      tag_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
      end else if (grant) begin
        pc_q     <= pc_q + XLEN'(4);
        tag_pc_q <= pc_q;
      end
    end
  end

  // Priority: redirect/flush bubble, then stall hold, then buffer, then response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= '0;
      id_pc_plus4 <= XLEN'(4);
    end else if (redirect_valid || flush_d) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (!stall_d) begin
      if (buf_valid) begin
        id_valid    <= 1'b1;
        id_inst     <= buf_entry.inst;
        id_pc       <= buf_entry.pc;
        id_pc_plus4 <= buf_entry.pc + XLEN'(4);
      end else if (accept) begin
        id_valid    <= 1'b1;
        id_inst     <= imem.rdata;
        id_pc       <= tag_pc_q;
        id_pc_plus4 <= tag_pc_q + XLEN'(4);
      end else begin
        id_valid <= 1'b0;
        id_inst  <= NOP_INST;
      end
    end
  end

endmodule
